// File: rtl/orpsoc_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | orpsoc_rst_pkg: shared types and helpers for the reset sequencer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package orpsoc_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } rst_state_e;

    localparam logic [1:0] RST_CAUSE_EXT  = 2'b01;
    localparam logic [1:0] RST_CAUSE_SOFT = 2'b10;

    // Wide enough to hold the larger of the two delay terminal values.
    function automatic int cnt_width(input int min_assert, input int stage_delay);
        int m;
        m = (min_assert > stage_delay) ? min_assert : stage_delay;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/orpsoc_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | orpsoc_rst_seq: staged, individually gated reset sequencer.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module orpsoc_rst_seq
    import orpsoc_rst_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int MIN_ASSERT  = 4,
    parameter int STAGE_DELAY = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rst_req_i,
    input  logic [NUM_CH-1:0] hold_i,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              init_done_o,
    output logic              busy_o,
    output logic [1:0]        rst_cause_o,
    output logic [7:0]        soft_cnt_o
);

    localparam int C_CNT_W = cnt_width(MIN_ASSERT, STAGE_DELAY);
    localparam int C_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [C_CNT_W-1:0] C_MA_LAST  = C_CNT_W'(MIN_ASSERT - 1);
    localparam logic [C_CNT_W-1:0] C_SD_LAST  = C_CNT_W'(STAGE_DELAY - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_CH - 1);

    rst_state_e          state_q, state_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic [C_IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0]   ch_rst_q, ch_rst_d;
    logic                init_done_q, init_done_d;
    logic [1:0]          cause_q, cause_d;
    logic [7:0]          soft_cnt_q, soft_cnt_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ASSERT;
            cnt_q       <= '0;
            idx_q       <= '0;
            ch_rst_q    <= '1;
            init_done_q <= 1'b0;
            cause_q     <= RST_CAUSE_EXT;
            soft_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ch_rst_q    <= ch_rst_d;
            init_done_q <= init_done_d;
            cause_q     <= cause_d;
            soft_cnt_q  <= soft_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        ch_rst_d    = ch_rst_q;
        init_done_d = init_done_q;
        cause_d     = cause_q;
        soft_cnt_d  = soft_cnt_q;

        if (rst_req_i) begin
            // A request during ASSERT only stretches the window; it is not a new event.
            cnt_d = '0;
            if (state_q != ASSERT) begin
                state_d     = ASSERT;
                idx_d       = '0;
                ch_rst_d    = '1;
                init_done_d = 1'b0;
                cause_d     = RST_CAUSE_SOFT;
                if (soft_cnt_q != 8'hFF) begin
                    soft_cnt_d = soft_cnt_q + 8'd1;
                end
            end
        end else begin
            case (state_q)
                ASSERT: begin
                    ch_rst_d = '1;
                    if (cnt_q == C_MA_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == C_SD_LAST) begin
                        if (!hold_i[idx_q]) begin
                            ch_rst_d[idx_q] = 1'b0;
                            cnt_d           = '0;
                            idx_d           = idx_q + C_IDX_W'(1);
                            if (idx_q == C_IDX_LAST) begin
                                state_d     = DONE;
                                init_done_d = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + C_CNT_W'(1);
                    end
                end
                default: begin
                    ch_rst_d = '0;
                end
            endcase
        end
    end

    assign ch_rst_o    = ch_rst_q;
    assign init_done_o = init_done_q;
    assign busy_o      = (state_q != DONE);
    assign rst_cause_o = cause_q;
    assign soft_cnt_o  = soft_cnt_q;

endmodule
`default_nettype wire
